// File: rtl/sdram_pkg.sv
// Shared command encodings, FSM states and address layout for the SDR SDRAM
// command scheduler and its refresh timer.
package sdram_pkg;

  localparam int BA_W    = 2;
  localparam int ROW_W   = 13;
  localparam int COL_W   = 9;
  localparam int ADDR_W  = BA_W + ROW_W + COL_W;
  localparam int COL_LSB = 0;
  localparam int ROW_LSB = COL_LSB + COL_W;
  localparam int BA_LSB  = ROW_LSB + ROW_W;

  // Encoded as {CS_N, RAS_N, CAS_N, WE_N}.
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_DESEL = 4'b1111;
  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_RD    = 4'b0101;
  localparam cmd_t CMD_WR    = 4'b0100;
  localparam cmd_t CMD_REF   = 4'b0001;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_REF,
    S_ACT,
    S_RW,
    S_RDWAIT,
    S_RECOV
  } state_t;

  // A10 high turns every READ/WRITE into an auto-precharge access.
  function automatic logic [ROW_W-1:0] rwAddr(input logic [COL_W-1:0] col);
    return {2'b00, 1'b1, 1'b0, col};
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a saturating pending flag; it
// is armed once the init sequence completes and cleared when REFRESH issues.
module sdram_refresh_timer #(
  parameter int REF_INTERVAL = 780
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic clr_i,
  output logic pending_o
);

  localparam int CNT_W = $clog2(REF_INTERVAL);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic             tick;

  // A tick while already pending simply leaves the flag set.
  always_comb begin
    run_d  = run_q | start_i;
    tick   = run_q && (cnt_q == '0);
    cnt_d  = cnt_q;
    if (start_i || tick) begin
      cnt_d = RELOAD;
    end else if (run_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    pend_d = tick || (pend_q && !clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/sdram_cmd_sched.sv
// SDR SDRAM command scheduler: runs the init handshake, then interleaves
// periodic AUTO REFRESH with single-word auto-precharge reads and writes.
module sdram_cmd_sched
  import sdram_pkg::*;
#(
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3,
  parameter int T_RC         = 9,
  parameter int T_WR         = 2,
  parameter int CAS_LAT      = 3,
  parameter int REF_INTERVAL = 780
) (
  input  logic              iclk,
  input  logic              ireset,
  output logic              oinit_req,
  output logic              oinit_enb,
  input  logic              iinit_fin,
  input  logic              ireq_valid,
  input  logic              ireq_we,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [15:0]       iwdata,
  output logic              oready,
  output logic [15:0]       ordata,
  output logic              ordata_valid,
  output logic              DRAM_CKE,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic [BA_W-1:0]   DRAM_BA,
  output logic [ROW_W-1:0]  DRAM_ADDR,
  output logic              DRAM_LDQM,
  output logic              DRAM_UDQM,
  inout  wire  [15:0]       DRAM_DQ
);

  localparam int WAIT_W = 8;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic                reqWe_q, reqWe_d;
  logic [ADDR_W-1:0]   reqAddr_q, reqAddr_d;
  logic [15:0]         reqData_q, reqData_d;
  cmd_t                cmd_q, cmd_d;
  logic [BA_W-1:0]     ba_q, ba_d;
  logic [ROW_W-1:0]    addr_q, addr_d;
  logic [1:0]          dqm_q, dqm_d;
  logic                dqOe_q, dqOe_d;
  logic [15:0]         dqOut_q, dqOut_d;
  logic                cke_q, cke_d;
  logic                init_q, init_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                refPending, refClr, timerStart;

  sdram_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_refTimer (
    .clk_i    (iclk),
    .reset_i  (ireset),
    .start_i  (timerStart),
    .clr_i    (refClr),
    .pending_o(refPending)
  );

  assign oready = (state_q == S_IDLE) && !refPending;

  // Commands are chosen on the transition into a state, so each state's
  // command is on the pins during that state's first cycle.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = (waitCnt_q != '0) ? waitCnt_q - WAIT_W'(1) : waitCnt_q;
    reqWe_d    = reqWe_q;
    reqAddr_d  = reqAddr_q;
    reqData_d  = reqData_q;
    cmd_d      = CMD_NOP;
    ba_d       = ba_q;
    addr_d     = addr_q;
    dqm_d      = 2'b11;
    dqOe_d     = 1'b0;
    dqOut_d    = dqOut_q;
    cke_d      = cke_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    refClr     = 1'b0;
    timerStart = 1'b0;
    case (state_q)
      S_INIT: begin
        cmd_d = CMD_DESEL;
        if (iinit_fin) begin
          cmd_d      = CMD_NOP;
          cke_d      = 1'b1;
          timerStart = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        if (refPending) begin
          cmd_d     = CMD_REF;
          refClr    = 1'b1;
          waitCnt_d = WAIT_W'(T_RC - 1);
          state_d   = S_REF;
        end else if (ireq_valid) begin
          reqWe_d   = ireq_we;
          reqAddr_d = iaddr;
          reqData_d = iwdata;
          cmd_d     = CMD_ACT;
          ba_d      = iaddr[BA_LSB +: BA_W];
          addr_d    = iaddr[ROW_LSB +: ROW_W];
          waitCnt_d = WAIT_W'(T_RCD - 1);
          state_d   = S_ACT;
        end
      end
      S_REF: begin
        if (waitCnt_q == '0) state_d = S_IDLE;
      end
      S_ACT: begin
        if (waitCnt_q == '0) begin
          cmd_d   = reqWe_q ? CMD_WR : CMD_RD;
          ba_d    = reqAddr_q[BA_LSB +: BA_W];
          addr_d  = rwAddr(reqAddr_q[COL_LSB +: COL_W]);
          dqm_d   = 2'b00;
          dqOe_d  = reqWe_q;
          dqOut_d = reqWe_q ? reqData_q : dqOut_q;
          state_d = S_RW;
        end
      end
      S_RW: begin
        if (reqWe_q) begin
          waitCnt_d = WAIT_W'(T_WR + T_RP - 1);
          state_d   = S_RECOV;
        end else begin
          dqm_d     = 2'b00;
          waitCnt_d = WAIT_W'(CAS_LAT - 1);
          state_d   = S_RDWAIT;
        end
      end
      // Masks stay open until the read word has been captured.
      S_RDWAIT: begin
        dqm_d = 2'b00;
        if (waitCnt_q == '0) begin
          dqm_d     = 2'b11;
          rdata_d   = DRAM_DQ;
          rvalid_d  = 1'b1;
          waitCnt_d = WAIT_W'(T_RP - 1);
          state_d   = S_RECOV;
        end
      end
      S_RECOV: begin
        if (waitCnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    init_d = (state_d == S_INIT);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= S_INIT;
      waitCnt_q <= '0;
      reqWe_q   <= 1'b0;
      reqAddr_q <= '0;
      reqData_q <= '0;
      cmd_q     <= CMD_DESEL;
      ba_q      <= '0;
      addr_q    <= '0;
      dqm_q     <= 2'b11;
      dqOe_q    <= 1'b0;
      dqOut_q   <= '0;
      cke_q     <= 1'b0;
      init_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      reqWe_q   <= reqWe_d;
      reqAddr_q <= reqAddr_d;
      reqData_q <= reqData_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      dqm_q     <= dqm_d;
      dqOe_q    <= dqOe_d;
      dqOut_q   <= dqOut_d;
      cke_q     <= cke_d;
      init_q    <= init_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign oinit_req    = init_q;
  assign oinit_enb    = init_q;
  assign ordata       = rdata_q;
  assign ordata_valid = rvalid_q;
  assign DRAM_CKE     = cke_q;
  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
  assign DRAM_BA      = ba_q;
  assign DRAM_ADDR    = addr_q;
  assign DRAM_LDQM    = dqm_q[0];
  assign DRAM_UDQM    = dqm_q[1];
  assign DRAM_DQ      = dqOe_q ? dqOut_q : 16'bz;

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Directed bench for sdram_cmd_sched: init handshake, write, read through a
// CAS-latency DQ model, refresh cadence/arbitration and reset mid-read.
module tb_sdram_cmd_sched;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] RD    = 4'b0101;
  localparam logic [3:0] WR    = 4'b0100;
  localparam logic [3:0] REFR  = 4'b0001;
  localparam logic [3:0] DESEL = 4'b1111;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        iinit_fin;
  logic        ireq_valid;
  logic        ireq_we;
  logic [23:0] iaddr;
  logic [15:0] iwdata;
  logic        oinit_req, oinit_enb, oready, ordata_valid;
  logic [15:0] ordata;
  logic        DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
  logic [1:0]  DRAM_BA;
  logic [12:0] DRAM_ADDR;
  logic        DRAM_LDQM, DRAM_UDQM;
  wire  [15:0] dramDq;

  logic        dqDrive;
  logic [15:0] dqModel;
  logic [15:0] rdWord;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mark;
  int          lowCount;

  logic [3:0]  cmdPins;
  logic [1:0]  dqmPins;
  logic        dqFloat;

  assign dramDq  = dqDrive ? dqModel : 16'hzzzz;
  assign cmdPins = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
  assign dqmPins = {DRAM_UDQM, DRAM_LDQM};
  assign dqFloat = (dramDq === 16'hzzzz) || (dramDq === 16'h0000);

  always #5 iclk = ~iclk;

  sdram_cmd_sched dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .oinit_req   (oinit_req),
    .oinit_enb   (oinit_enb),
    .iinit_fin   (iinit_fin),
    .ireq_valid  (ireq_valid),
    .ireq_we     (ireq_we),
    .iaddr       (iaddr),
    .iwdata      (iwdata),
    .oready      (oready),
    .ordata      (ordata),
    .ordata_valid(ordata_valid),
    .DRAM_CKE    (DRAM_CKE),
    .DRAM_CS_N   (DRAM_CS_N),
    .DRAM_RAS_N  (DRAM_RAS_N),
    .DRAM_CAS_N  (DRAM_CAS_N),
    .DRAM_WE_N   (DRAM_WE_N),
    .DRAM_BA     (DRAM_BA),
    .DRAM_ADDR   (DRAM_ADDR),
    .DRAM_LDQM   (DRAM_LDQM),
    .DRAM_UDQM   (DRAM_UDQM),
    .DRAM_DQ     (dramDq)
  );

  // DRAM data model: a READ seen on the pins returns rdWord three cycles later.
  initial begin
    dqDrive = 1'b0;
    dqModel = '0;
    forever begin
      @(posedge iclk);
      #2;
      if (cmdPins === RD) begin
        repeat (3) @(posedge iclk);
        #2;
        dqModel = rdWord;
        dqDrive = 1'b1;
        @(posedge iclk);
        #2;
        dqDrive = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
    cyc++;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic applyStimulus(input logic valid, input logic we,
                               input logic [23:0] addr, input logic [15:0] wdata);
    ireq_valid = valid;
    ireq_we    = we;
    iaddr      = addr;
    iwdata     = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h",
             tag, cyc, observed, expected);
    end
  endtask

  initial begin
    ireset    = 1'b1;
    iinit_fin = 1'b0;
    rdWord    = '0;
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
    repeat (3) @(posedge iclk);
    #1;
    $display("[TB] reset values");
    checkOutput("rstInitReq", oinit_req, 0);
    checkOutput("rstInitEnb", oinit_enb, 0);
    checkOutput("rstReady", oready, 0);
    checkOutput("rstRdata", ordata, 0);
    checkOutput("rstRvalid", ordata_valid, 0);
    checkOutput("rstCke", DRAM_CKE, 0);
    checkOutput("rstCmd", cmdPins, DESEL);
    checkOutput("rstBa", DRAM_BA, 0);
    checkOutput("rstAddr", DRAM_ADDR, 0);
    checkOutput("rstDqm", dqmPins, 2'b11);
    checkOutput("rstDqZ", dqFloat, 1);

    ireset = 1'b0;
    cyc    = 0;
    $display("[TB] init handshake");
    for (int c = 1; c <= 20; c++) begin
      tick();
      checkOutput("initHandshake", {oinit_req, oinit_enb}, 2'b11);
      checkOutput("initCkeLow", DRAM_CKE, 0);
    end
    iinit_fin = 1'b1;
    tick();
    iinit_fin = 1'b0;
    checkOutput("initDone", {oinit_req, oinit_enb}, 2'b00);
    checkOutput("initCke", DRAM_CKE, 1);
    checkOutput("initReady", oready, 1);
    checkOutput("initNop", cmdPins, NOP);

    $display("[TB] write 5A1234 <= BEEF");
    applyStimulus(1'b1, 1'b1, 24'h5A1234, 16'hBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
    checkOutput("wrActCmd", cmdPins, ACT);
    checkOutput("wrActBa", DRAM_BA, 1);
    checkOutput("wrActRow", DRAM_ADDR, 13'h0D09);
    checkOutput("wrBusyReady", oready, 0);
    tick();
    checkOutput("wrRcdNop", cmdPins, NOP);
    waitCycle(25);
    checkOutput("wrCmd", cmdPins, WR);
    checkOutput("wrAddr", DRAM_ADDR, 13'h0434);
    checkOutput("wrBa", DRAM_BA, 1);
    checkOutput("wrDq", dramDq, 16'hBEEF);
    checkOutput("wrDqm", dqmPins, 2'b00);
    tick();
    checkOutput("wrAfterCmd", cmdPins, NOP);
    checkOutput("wrAfterDqZ", dqFloat, 1);
    checkOutput("wrAfterDqm", dqmPins, 2'b11);
    waitCycle(30);
    checkOutput("wrRecovReady", oready, 0);
    tick();
    checkOutput("wrDoneReady", oready, 1);

    $display("[TB] read 5A1234");
    rdWord = 16'hBEEF;
    applyStimulus(1'b1, 1'b0, 24'h5A1234, 16'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
    checkOutput("rdActCmd", cmdPins, ACT);
    checkOutput("rdActRow", DRAM_ADDR, 13'h0D09);
    waitCycle(35);
    checkOutput("rdCmd", cmdPins, RD);
    checkOutput("rdAddr", DRAM_ADDR, 13'h0434);
    checkOutput("rdDqm", dqmPins, 2'b00);
    for (int c = 36; c <= 41; c++) begin
      tick();
      checkOutput("rdValidStrobe", ordata_valid, (cyc == 39));
      if (cyc == 39) checkOutput("rdData", ordata, 16'hBEEF);
    end
    tick();
    checkOutput("rdDoneReady", oready, 1);

    $display("[TB] idle refresh");
    waitCycle(800);
    checkOutput("refPreReady", oready, 1);
    tick();
    checkOutput("refPendReady", oready, 0);
    mark = -1;
    while (mark < 0 && cyc < 900) begin
      tick();
      if (cmdPins === REFR) mark = cyc;
    end
    checkOutput("refFirstCycle", mark, 802);
    lowCount = 0;
    while (!oready && cyc < 840) begin
      lowCount++;
      tick();
    end
    checkOutput("refBusyCycles", lowCount, 9);
    checkOutput("refDoneCycle", cyc, 811);

    $display("[TB] request while refresh pending");
    waitCycle(1580);
    checkOutput("ref2PreReady", oready, 1);
    tick();
    checkOutput("ref2PendReady", oready, 0);
    rdWord = 16'h1234;
    applyStimulus(1'b1, 1'b0, 24'hC3FE01, 16'h0);
    tick();
    checkOutput("ref2Cmd", cmdPins, REFR);
    while (!oready && cyc < 1620) tick();
    checkOutput("ref2AcceptCycle", cyc, 1591);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
    checkOutput("ref2ActCmd", cmdPins, ACT);
    checkOutput("ref2ActBa", DRAM_BA, 3);
    checkOutput("ref2ActRow", DRAM_ADDR, 13'h01FF);
    waitCycle(1595);
    checkOutput("ref2RdCmd", cmdPins, RD);
    checkOutput("ref2RdAddr", DRAM_ADDR, 13'h0401);
    waitCycle(1599);
    checkOutput("ref2Rvalid", ordata_valid, 1);
    checkOutput("ref2Rdata", ordata, 16'h1234);
    tick();
    checkOutput("ref2RvalidOff", ordata_valid, 0);

    $display("[TB] request in the refresh tick cycle");
    waitCycle(2360);
    checkOutput("tickReady", oready, 1);
    applyStimulus(1'b1, 1'b1, 24'h800200, 16'hA5A5);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
    checkOutput("tickActCmd", cmdPins, ACT);
    checkOutput("tickActBa", DRAM_BA, 2);
    checkOutput("tickActRow", DRAM_ADDR, 13'h0001);
    waitCycle(2364);
    checkOutput("tickWrCmd", cmdPins, WR);
    checkOutput("tickWrAddr", DRAM_ADDR, 13'h0400);
    checkOutput("tickWrDq", dramDq, 16'hA5A5);
    waitCycle(2370);
    checkOutput("tickIdlePendReady", oready, 0);
    tick();
    checkOutput("tickRefCmd", cmdPins, REFR);

    $display("[TB] reset during read wait");
    waitCycle(2380);
    checkOutput("midReady", oready, 1);
    rdWord = 16'hDEAD;
    applyStimulus(1'b1, 1'b0, 24'h5A1234, 16'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0);
    waitCycle(2384);
    checkOutput("midRdCmd", cmdPins, RD);
    tick();
    ireset = 1'b1;
    tick();
    ireset = 1'b0;
    checkOutput("midRstCmd", cmdPins, DESEL);
    checkOutput("midRstCke", DRAM_CKE, 0);
    checkOutput("midRstInit", {oinit_req, oinit_enb}, 2'b00);
    checkOutput("midRstReady", oready, 0);
    checkOutput("midRstRvalid", ordata_valid, 0);
    checkOutput("midRstRdata", ordata, 0);
    checkOutput("midRstDqm", dqmPins, 2'b11);
    checkOutput("midRstAddr", {DRAM_BA, DRAM_ADDR}, 0);
    checkOutput("midRstDqZ", dqFloat, 1);
    tick();
    checkOutput("midReinit", {oinit_req, oinit_enb}, 2'b11);
    for (int c = 2388; c <= 2392; c++) begin
      tick();
      checkOutput("midNoRvalid", ordata_valid, 0);
      checkOutput("midNoRdata", ordata, 0);
      checkOutput("midStillInit", oinit_req, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
